cdc_handshake_arbiter: RTL and testbench
========================================

// Module: cdc_handshake_arbiter
// PURPOSE
//  Source-domain (sCLK) controller that shares one 4-phase req/ack bundled-data CDC channel among NREQ requesters.
//  Round-robin arbiter. Latches the winner's payload and drives the req level into a SyncBit-style synchronizer.
//  Sequences the handshake against the ack, which is already synchronized back into sCLK.
//  Flags acks that never arrive with a sticky timeout error.
// PARAMETERS
//  NREQ          4     number of requesters (2..8)
//  DW            8     payload width per requester
//  IDW           2     width of xfer_id; must equal clog2(NREQ)
//  SETUP_CYCLES  1     cycles xfer_data/xfer_id are held stable before sync_req rises (1..15)
//  TIMEOUT       1024  max wait cycles per handshake phase before timeout_err; 0 disables; max 65535
// PORTS
//  sCLK         in   1        clock, all logic on posedge
//  sRST         in   1        reset, synchronous, active-high
//  req_valid    in   NREQ     per-requester request, held until its req_ready pulse
//  req_data     in   NREQ*DW  payloads; requester i at bits [i*DW +: DW]
//  req_ready    out  NREQ     one-hot, 1-cycle pulse: requester's transfer fully complete
//  xfer_data    out  DW       bundled payload to destination; stable for the whole handshake
//  xfer_id      out  IDW      index of the requester being served
//  sync_en      out  1        enable into req synchronizer
//  sync_req     out  1        req level into req synchronizer
//  sync_ack     in   1        destination ack, already synchronized to sCLK
//  busy         out  1        high in any state other than IDLE
//  timeout_err  out  1        sticky timeout flag
//  err_clr      in   1        clears timeout_err
// BEHAVIOUR
//  Reset (sRST=1 at posedge):
//   - state=IDLE; sync_req=0, sync_en=0, req_ready=0, xfer_data=0, xfer_id=0, busy=0, timeout_err=0, counters=0.
//   - last_grant=NREQ-1, so requester 0 has first priority.
//  Reset mid-handshake: next cycle sync_req=0 and no req_ready pulse; the destination side is reset by its own domain.
//  All outputs are registered.
//  FSM:
//   - IDLE: when |req_valid and sync_ack==0, pick the first valid index scanning last_grant+1, +2, ... (mod NREQ).
//     Latch xfer_data/xfer_id from it. Go to SETUP.
//     While sync_ack==1 (stale ack, e.g. after reset), stay in IDLE and grant nothing.
//   - SETUP: count SETUP_CYCLES cycles, then go to REQ_HI.
//   - REQ_HI: sync_req=1, sync_en=1. When sync_ack==1, go to REQ_LO.
//   - REQ_LO: sync_req=0, sync_en=1. When sync_ack==0, go to DONE.
//   - DONE: req_ready[xfer_id]=1 for exactly this cycle; last_grant=xfer_id; go to IDLE.
//  xfer_data/xfer_id change only on the IDLE->SETUP edge. Later changes on req_data are ignored.
//  Latency, ack modelled as sync_req delayed D cycles:
//   - sync_req rises 1+SETUP_CYCLES cycles after the granting edge.
//   - req_ready pulses 1 cycle after sync_ack==0 is seen in REQ_LO.
//   - Back-to-back: the next grant can occur in the IDLE cycle right after DONE.
//  Requester deasserting req_valid:
//   - before grant: it is skipped.
//   - after grant: transfer still completes and req_ready still pulses.
//  Timeout:
//   - 16-bit wait counter, cleared on entry to REQ_HI and to REQ_LO, increments each cycle in those states.
//   - When it reaches TIMEOUT (TIMEOUT!=0): timeout_err=1. Counter saturates; the FSM keeps waiting (never aborts the CDC handshake).
//   - err_clr=1 clears timeout_err next cycle; a set in the same cycle wins over the clear.
//  busy=1 in SETUP, REQ_HI, REQ_LO and DONE.
// TESTING
//  1. NREQ=4, req_valid=0001, data0=0xA5, ack = sync_req delayed 3 cycles
//     -> xfer_data=0xA5, xfer_id=0; sync_req high 2 cycles after grant; single req_ready=0001 pulse; busy low after.
//  2. req_valid=1111 held, each requester drops valid after its ready
//     -> grant order 0,1,2,3; re-assert all -> order 0,1,2,3 again (round-robin from last_grant).
//  3. TIMEOUT=16, ack tied 0 -> timeout_err=1 after 16 cycles in REQ_HI, sync_req stays 1;
//     release ack -> handshake completes; err_clr -> timeout_err=0.
//  4. sRST for 1 cycle during REQ_HI -> next cycle sync_req=0, busy=0, no req_ready;
//     hold sync_ack=1 for 5 cycles with req_valid=0010 -> no grant until ack=0, then xfer_id=1.
//  5. req_data0 changed 0xA5->0x3C during REQ_HI -> xfer_data stays 0xA5 until DONE.
//  6. err_clr and timeout condition in the same cycle -> timeout_err remains 1.

Source files
------------

// File: rtl/cdc_handshake_arbiter.sv
// cdc_handshake_arbiter: round-robin sharing of one 4-phase req/ack CDC channel, with sticky ack timeout
module cdc_handshake_arbiter #(
    parameter int NREQ         = 4,
    parameter int DW           = 8,
    parameter int IDW          = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic               sCLK,
    input  logic               sRST,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic [DW-1:0]      xfer_data_o,
    output logic [IDW-1:0]     xfer_id_o,
    output logic               sync_en_o,
    output logic               sync_req_o,
    input  logic               sync_ack_i,
    output logic               busy_o,
    output logic               timeout_err_o,
    input  logic               err_clr_i
);
    typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, REQ_LO, DONE} state_t;
    localparam logic [15:0] SETUP_END = 16'(SETUP_CYCLES);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [IDW-1:0] last_q, id_q, win;
    logic [IDW:0] scan;
    logic [NREQ-1:0] ready_q;
    logic [DW-1:0] data_q;
    logic found, grant, hit, sreq_q, sen_q, busy_q, err_q;
    always_comb begin
        win = '0;
        found = 1'b0;
        scan = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = {1'b0, last_q} + (IDW+1)'(k);
            scan = (scan >= (IDW+1)'(NREQ)) ? scan - (IDW+1)'(NREQ) : scan;
            if (!found && req_valid_i[scan[IDW-1:0]]) begin
                found = 1'b1;
                win = scan[IDW-1:0];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        grant = 1'b0;
        case (state_q)
            IDLE: if (found && !sync_ack_i) begin
                state_d = SETUP;
                grant = 1'b1;
            end
            SETUP: if (cnt_q == SETUP_END) state_d = REQ_HI;
            REQ_HI: if (sync_ack_i) state_d = REQ_LO;
            REQ_LO: if (!sync_ack_i) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // one counter serves both the setup delay and the per-phase ack wait; it restarts on every state change
    assign cnt_d = state_d != state_q ? '0 : cnt_q + 16'(cnt_q != 16'hFFFF);
    assign hit = TIMEOUT != 0 && (state_q == REQ_HI || state_q == REQ_LO) && cnt_q == TO_LAST;
    always_ff @(posedge sCLK) begin
        if (sRST) begin
            state_q <= IDLE;
            cnt_q <= '0;
            last_q <= IDW'(NREQ - 1);
            id_q <= '0;
            data_q <= '0;
            ready_q <= '0;
            sreq_q <= 1'b0;
            sen_q <= 1'b0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (grant) begin
                data_q <= req_data_i[win*DW +: DW];
                id_q <= win;
            end
            if (state_q == DONE) last_q <= id_q;
            ready_q <= state_d == DONE ? NREQ'(1) << id_q : '0;
            sreq_q <= state_d == REQ_HI;
            sen_q <= state_d == REQ_HI || state_d == REQ_LO;
            busy_q <= state_d != IDLE;
            err_q <= hit | (err_q & ~err_clr_i);
        end
    end
    assign req_ready_o = ready_q;
    assign xfer_data_o = data_q;
    assign xfer_id_o = id_q;
    assign sync_req_o = sreq_q;
    assign sync_en_o = sen_q;
    assign busy_o = busy_q;
    assign timeout_err_o = err_q;
endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// tb_cdc_handshake_arbiter: vector table, directed corner sequences and random traffic against a transaction-level model
module tb_cdc_handshake_arbiter;
    localparam int NREQ = 4, DW = 8, IDW = 2, SC = 1, TO = 16;
    localparam logic [31:0] D0 = 32'h443322A5;
    logic sCLK = 1'b0, sRST = 1'b1;
    logic [NREQ-1:0] req_valid = '0, req_ready_o;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [DW-1:0] xfer_data_o;
    logic [IDW-1:0] xfer_id_o;
    logic sync_en_o, sync_req_o, busy_o, timeout_err_o;
    logic sync_ack = 1'b0, err_clr = 1'b0;
    int errors = 0, checks = 0;
    int m_st, m_last, m_id, m_cnt;
    logic [DW-1:0] m_data;
    logic m_err;
    int ack_mode = 3, ack_d = 3;
    logic [31:0] dl = '0;
    logic [17:0] dut_v;
    typedef struct {
        logic [3:0] v;
        logic a;
        logic [3:0] rdy;
        logic [7:0] xd;
        logic [1:0] xid;
        logic sen, sreq, busy;
    } vec_t;
    vec_t tbl[21];

    cdc_handshake_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .SETUP_CYCLES(SC), .TIMEOUT(TO)) dut (
        .sCLK(sCLK), .sRST(sRST), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready_o), .xfer_data_o(xfer_data_o), .xfer_id_o(xfer_id_o),
        .sync_en_o(sync_en_o), .sync_req_o(sync_req_o), .sync_ack_i(sync_ack),
        .busy_o(busy_o), .timeout_err_o(timeout_err_o), .err_clr_i(err_clr)
    );

    always #5 sCLK = ~sCLK;
    assign dut_v = {req_ready_o, xfer_data_o, xfer_id_o, sync_en_o, sync_req_o, busy_o, timeout_err_o};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    // transaction view: phase 0 idle, 1 setup, 2 req high, 3 req low, 4 done; m_cnt = edges spent in the phase
    function automatic logic [17:0] m_out();
        logic [3:0] r;
        r = (m_st == 4) ? 4'b0001 << m_id : 4'b0000;
        return {r, m_data, 2'(m_id), m_st == 2 || m_st == 3, m_st == 2, m_st != 0, m_err};
    endfunction

    task automatic model_step();
        bit set;
        int i;
        if (sRST) begin
            m_st = 0; m_last = NREQ - 1; m_id = 0; m_cnt = 0; m_data = '0; m_err = 1'b0;
        end else begin
            set = 0;
            if (m_st == 0) begin
                if (req_valid != 0 && !sync_ack)
                    for (int k = 1; k <= NREQ; k++) begin
                        i = (m_last + k) % NREQ;
                        if (m_st == 0 && req_valid[i]) begin
                            m_id = i; m_data = req_data[i*DW +: DW]; m_st = 1; m_cnt = 0;
                        end
                    end
            end else if (m_st == 1) begin
                m_cnt++;
                if (m_cnt > SC) begin m_st = 2; m_cnt = 0; end
            end else if (m_st == 2 || m_st == 3) begin
                m_cnt++;
                if (TO != 0 && m_cnt == TO) set = 1;
                if (m_st == 2 && sync_ack) begin m_st = 3; m_cnt = 0; end
                else if (m_st == 3 && !sync_ack) begin m_st = 4; m_cnt = 0; end
            end else begin
                m_last = m_id; m_st = 0;
            end
            m_err = set ? 1'b1 : err_clr ? 1'b0 : m_err;
        end
    endtask

    task automatic tick();
        @(posedge sCLK);
        model_step();
        #1;
        chk("model", 32'(dut_v), 32'(m_out()));
        dl = {dl[30:0], sync_req_o};
        if (ack_mode == 0) sync_ack = dl[ack_d-1];
        else if (ack_mode == 1) sync_ack = 1'b0;
        else if (ack_mode == 2) sync_ack = 1'b1;
    endtask

    task automatic do_reset();
        sRST = 1'b1;
        tick(); tick();
        sRST = 1'b0;
    endtask

    task automatic wait_sreq(input string nm);
        int c = 0;
        while (!sync_req_o && c < 50) begin tick(); c++; end
        chk(nm, 32'(sync_req_o), 1);
    endtask

    task automatic wait_ready(input string nm);
        int c = 0;
        do begin tick(); c++; end while (req_ready_o == 0 && c < 200);
        chk(nm, 32'(req_ready_o != 0), 1);
        req_valid = req_valid & ~req_ready_o;
    endtask

    task automatic rr_round();
        int got = 0;
        req_valid = 4'hF;
        req_data = {$urandom};
        for (int c = 0; c < 200 && got < 4; c++) begin
            tick();
            if (req_ready_o != 0) begin
                chk("rr_order", 32'(req_ready_o), 32'(4'b0001 << got));
                req_valid = req_valid & ~req_ready_o;
                got++;
            end
        end
        chk("rr_count", got, 4);
    endtask

    initial begin
        tbl[0]  = '{4'h1, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{4'h1, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{4'h1, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{4'h1, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{4'h1, 1'b1, 4'h0, 8'hA5, 2'd0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{4'h1, 1'b1, 4'h0, 8'hA5, 2'd0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{4'h1, 1'b0, 4'h1, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'h0, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'h4, 1'b0, 4'h0, 8'h33, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{4'h0, 1'b0, 4'h0, 8'h33, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{4'h0, 1'b0, 4'h0, 8'h33, 2'd2, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{4'h0, 1'b1, 4'h0, 8'h33, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{4'h0, 1'b0, 4'h4, 8'h33, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{4'h0, 1'b0, 4'h0, 8'h33, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{4'h1, 1'b1, 4'h0, 8'h33, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{4'h1, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{4'h1, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{4'h1, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b1, 1'b1, 1'b1};
        tbl[18] = '{4'h1, 1'b1, 4'h0, 8'hA5, 2'd0, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{4'h1, 1'b0, 4'h1, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{4'h0, 1'b0, 4'h0, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0};

        do_reset();
        chk("reset", 32'(dut_v), 0);
        req_data = D0;
        for (int i = 0; i < 21; i++) begin
            req_valid = tbl[i].v;
            sync_ack = tbl[i].a;
            tick();
            chk($sformatf("table[%0d]", i), 32'(dut_v),
                32'({tbl[i].rdy, tbl[i].xd, tbl[i].xid, tbl[i].sen, tbl[i].sreq, tbl[i].busy, 1'b0}));
        end

        ack_mode = 0; ack_d = 3; dl = '0; sync_ack = 1'b0;
        do_reset();
        rr_round();
        rr_round();

        req_data = 32'h000000A5;
        req_valid = 4'b0001;
        wait_sreq("data_sreq");
        req_data[7:0] = 8'h3C;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("data_hold", 32'(xfer_data_o), 32'hA5);
            if (req_ready_o != 0) break;
        end
        chk("data_ready", 32'(req_ready_o), 1);
        req_valid = '0;

        ack_mode = 1;
        req_valid = 4'b0010;
        wait_sreq("to_sreq");
        begin
            int n = 0;
            while (!timeout_err_o && n < 100) begin tick(); n++; end
            chk("timeout_cycles", n, TO);
            chk("timeout_sreq_held", 32'(sync_req_o), 1);
        end
        ack_mode = 0;
        wait_ready("to_ready");
        err_clr = 1'b1;
        tick();
        chk("err_clr", 32'(timeout_err_o), 0);

        ack_mode = 1;
        req_valid = 4'b0100;
        begin
            int n = 0;
            while (!timeout_err_o && n < 100) begin tick(); n++; end
            chk("set_wins", 32'(timeout_err_o), 1);
        end
        tick();
        err_clr = 1'b0;
        ack_mode = 0;
        wait_ready("set_wins_ready");

        ack_mode = 1;
        req_valid = 4'b0010;
        wait_sreq("rst_sreq");
        sRST = 1'b1;
        tick();
        sRST = 1'b0;
        chk("rst_mid", 32'({sync_req_o, busy_o, req_ready_o}), 0);
        ack_mode = 2; sync_ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stale_ack", 32'(busy_o), 0);
        end
        ack_mode = 1; sync_ack = 1'b0;
        tick();
        chk("post_stale_id", 32'({busy_o, xfer_id_o}), 32'({1'b1, 2'd1}));
        ack_mode = 0;
        wait_ready("post_stale_ready");

        for (int c = 0; c < 1500; c++) begin
            if (m_st == 0 && $urandom_range(0, 15) == 0) ack_d = $urandom_range(1, 24);
            if (m_st == 4) req_valid[m_id] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*DW +: DW] = 8'($urandom);
                    end
                end else if (!(m_st != 0 && m_st != 4 && m_id == i)) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                    else if ($urandom_range(0, 7) == 0) req_data[i*DW +: DW] = 8'($urandom);
                end
            end
            err_clr = $urandom_range(0, 7) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
